// File: rtl/data_sram_responder_pkg.sv
// data_sram_responder_pkg: shared state encoding, size codes and data width
package data_sram_responder_pkg;
   localparam int DATA_W = 32;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   localparam logic [1:0] SIZE_B = 2'd0;
   localparam logic [1:0] SIZE_H = 2'd1;
   localparam logic [1:0] SIZE_W = 2'd2;
endpackage

// File: rtl/data_sram_responder_ram.sv
// data_ram_array: single-port byte-enabled RAM with a registered read port
module data_ram_array
   import data_sram_responder_pkg::*;
#(
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              re,
   input  logic [3:0]        we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   logic [DATA_W-1:0] mem [2**ADDR_W];
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++)
         if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
   end
   // Read word is held until the next read, so writes never disturb it
   always_ff @(posedge clk) begin
      if (!resetn) rdata <= '0;
      else if (re) rdata <= mem[addr];
   end
endmodule

// File: rtl/data_sram_responder.sv
// data_sram_responder: fixed-latency SRAM responder, one transaction outstanding at a time
module data_sram_responder
   import data_sram_responder_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int LATENCY = 1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        data_sram_req,
   input  logic        data_sram_wr,
   input  logic [1:0]  data_sram_size,
   input  logic [3:0]  data_sram_wstrb,
   input  logic [31:0] data_sram_addr,
   input  logic [31:0] data_sram_wdata,
   output logic        data_sram_addr_ok,
   output logic        data_sram_data_ok,
   output logic [31:0] data_sram_rdata
);
   state_t     state;
   logic [3:0] cnt;
   logic       hs;
   logic       unused;
   assign data_sram_addr_ok = state == IDLE;
   assign data_sram_data_ok = state == RESP;
   assign hs = data_sram_req && data_sram_addr_ok && resetn;
   assign unused = ^{data_sram_size, data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};
   data_ram_array #(.ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .resetn(resetn),
      .re    (hs && !data_sram_wr),
      .we    (hs && data_sram_wr ? data_sram_wstrb : 4'b0000),
      .addr  (data_sram_addr[ADDR_W+1:2]),
      .wdata (data_sram_wdata),
      .rdata (data_sram_rdata)
   );
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         case (state)
            IDLE: if (hs) begin
               state <= LATENCY == 1 ? RESP : WAIT;
               cnt   <= 4'(LATENCY - 1);
            end
            WAIT: begin
               cnt <= cnt - 4'd1;
               if (cnt == 4'd1) state <= RESP;
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_data_sram_responder.sv
// tb_data_sram_responder: directed scoreboard bench over latency 1, 3 and 4 instances
module tb_data_sram_responder;
   logic        clk = 0;
   logic        resetn = 0;
   logic        req = 0;
   logic        wr = 0;
   logic [1:0]  size = 2'd2;
   logic [3:0]  wstrb = 4'hf;
   logic [31:0] addr = 0;
   logic [31:0] wdata = 0;
   logic        aok1, dok1, aok3, dok3, aok4, dok4;
   logic [31:0] rd1, rd3, rd4;
   int          n_chk = 0;
   int          n_fail = 0;
   logic        mon_on = 0;
   logic [31:0] q [$];
   logic [31:0] mdl [1024];
   logic [31:0] last_rd = 0;
   always #5 clk = ~clk;
   data_sram_responder #(.ADDR_W(10), .LATENCY(1)) u1 (
      .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
      .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .data_sram_addr_ok(aok1), .data_sram_data_ok(dok1),
      .data_sram_rdata(rd1));
   data_sram_responder #(.ADDR_W(10), .LATENCY(3)) u3 (
      .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
      .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .data_sram_addr_ok(aok3), .data_sram_data_ok(dok3),
      .data_sram_rdata(rd3));
   data_sram_responder #(.ADDR_W(10), .LATENCY(4)) u4 (
      .clk(clk), .resetn(resetn), .data_sram_req(req), .data_sram_wr(wr),
      .data_sram_size(size), .data_sram_wstrb(wstrb), .data_sram_addr(addr),
      .data_sram_wdata(wdata), .data_sram_addr_ok(aok4), .data_sram_data_ok(dok4),
      .data_sram_rdata(rd4));
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // Model update and expectation push for a request on the latency-1 instance
   task automatic expect_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      if (w) begin
         for (int i = 0; i < 4; i++)
            if (s[i]) mdl[a[11:2]][8*i +: 8] = d[8*i +: 8];
      end else last_rd = mdl[a[11:2]];
      q.push_back(last_rd);
   endtask
   task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      int n = 0;
      @(negedge clk);
      req = 1; wr = w; addr = a; wdata = d; wstrb = s;
      expect_txn(w, a, d, s);
      while (!aok1 && n < 50) begin @(negedge clk); n++; end
      check("addr_ok_wait", {31'b0, aok1}, 1);
      @(posedge clk); #1;
      req = 0;
      check("data_ok_lat1", {31'b0, dok1}, 1);
      check("addr_ok_busy", {31'b0, aok1}, 0);
      @(posedge clk); #1;
      check("addr_ok_back", {31'b0, aok1}, 1);
      check("data_ok_pulse", {31'b0, dok1}, 0);
   endtask
   task automatic do_reset();
      @(negedge clk);
      resetn = 0; req = 0;
      @(negedge clk);
      @(negedge clk);
      resetn = 1;
   endtask
   always @(negedge clk) begin
      if (mon_on && dok1) begin
         check("queue_nonempty", {31'b0, q.size() > 0}, 1);
         if (q.size() > 0) check("rdata", rd1, q.pop_front());
      end
   end
   initial begin
      int seen;
      for (int i = 0; i < 1024; i++) mdl[i] = 0;
      do_reset();
      check("rst_addr_ok", {31'b0, aok1}, 1);
      check("rst_data_ok", {31'b0, dok1}, 0);
      check("rst_rdata", rd1, 0);
      check("rst_addr_ok4", {31'b0, aok4}, 1);
      mon_on = 1;
      txn(1, 32'h10, 32'hDEADBEEF, 4'hf);
      txn(0, 32'h10, 0, 4'hf);
      txn(1, 32'h20, 32'h11223344, 4'hf);
      txn(1, 32'h20, 32'hAABBCCDD, 4'b0101);
      txn(0, 32'h20, 0, 4'hf);
      txn(1, 32'h20, 32'h99999999, 4'b0000);
      txn(0, 32'h20, 0, 4'hf);
      size = 2'd0;
      txn(1, 32'h23, 32'h01020304, 4'hf);
      size = 2'd2;
      txn(0, 32'h20, 0, 4'hf);
      txn(1, 32'h1004, 32'h5A5A5A5A, 4'hf);
      txn(0, 32'h4, 0, 4'hf);
      txn(1, 32'h30, 32'h0, 4'hf);
      // Write driven during RESP of a read must wait for the next IDLE
      @(negedge clk);
      req = 1; wr = 0; addr = 32'h30;
      expect_txn(0, 32'h30, 0, 4'hf);
      @(posedge clk); #1;
      check("rd30_data_ok", {31'b0, dok1}, 1);
      @(negedge clk);
      wr = 1; wdata = 32'hFFFFFFFF; wstrb = 4'hf;
      check("resp_no_accept", {31'b0, aok1}, 0);
      @(posedge clk); #1;
      check("resp_then_idle", {31'b0, aok1}, 1);
      expect_txn(1, 32'h30, 32'hFFFFFFFF, 4'hf);
      @(posedge clk); #1;
      req = 0;
      check("late_wr_data_ok", {31'b0, dok1}, 1);
      @(posedge clk);
      txn(0, 32'h30, 0, 4'hf);
      @(negedge clk);
      check("queue_empty", q.size(), 0);
      mon_on = 0;
      do_reset();
      req = 1; wr = 0; addr = 0;
      for (int c = 0; c < 20; c++) begin
         check($sformatf("l4_addr_ok_c%0d", c), {31'b0, aok4}, {31'b0, c % 5 == 0});
         check($sformatf("l4_data_ok_c%0d", c), {31'b0, dok4}, {31'b0, c % 5 == 4});
         check("l4_exclusive", {31'b0, aok4 && dok4}, 0);
         @(negedge clk);
      end
      do_reset();
      req = 1; wr = 0; addr = 32'h10;
      @(posedge clk); #1;
      req = 0;
      check("l3_wait", {31'b0, aok3}, 0);
      @(negedge clk);
      resetn = 0;
      @(posedge clk); #1;
      check("l3_rst_addr_ok", {31'b0, aok3}, 1);
      check("l3_rst_data_ok", {31'b0, dok3}, 0);
      check("l3_rst_rdata", rd3, 0);
      @(negedge clk);
      resetn = 1;
      seen = 0;
      repeat (6) begin @(negedge clk); if (dok3) seen++; end
      check("l3_abandoned", seen, 0);
      req = 1; wr = 1; addr = 32'h40; wdata = 32'hCAFEF00D; wstrb = 4'hf;
      @(posedge clk); #1;
      req = 0;
      @(negedge clk);
      resetn = 0;
      @(negedge clk);
      resetn = 1;
      req = 1; wr = 0; addr = 32'h40;
      @(posedge clk); #1;
      req = 0;
      @(posedge clk); #1;
      check("l3_not_yet", {31'b0, dok3}, 0);
      @(posedge clk); #1;
      check("l3_data_ok", {31'b0, dok3}, 1);
      check("l3_committed_wr", rd3, 32'hCAFEF00D);
      @(posedge clk); #1;
      check("l3_idle_after", {31'b0, aok3}, 1);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/data_sram_responder.md
DATA_SRAM_RESPONDER -- requirements
Module: data_sram_responder

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 10, giving the word-index width (memory depth 2^ADDR_W words of 32 bits).
REQ-002 The block SHALL have parameter LATENCY, default 1, legal range 1..15, giving the cycles from request acceptance to data_ok.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port resetn, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port data_sram_req, input, 1, request valid from the initiator.
REQ-006 The block SHALL have port data_sram_wr, input, 1, where 1 means write and 0 means read.
REQ-007 The block SHALL have port data_sram_size, input, 2, where 0 means byte, 1 means half and 2 means word (informational only).
REQ-008 The block SHALL have port data_sram_wstrb, input, 4, the byte write enables, used only when wr=1.
REQ-009 The block SHALL have port data_sram_addr, input, 32, the byte address.
REQ-010 The block SHALL have port data_sram_wdata, input, 32, the write data.
REQ-011 The block SHALL have port data_sram_addr_ok, output, 1, signalling that the request is accepted this cycle.
REQ-012 The block SHALL have port data_sram_data_ok, output, 1, a one-cycle completion pulse for both reads and writes.
REQ-013 The block SHALL have port data_sram_rdata, output, 32, the read data, valid while data_ok=1.

Function
REQ-014 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-015 data_sram_addr_ok SHALL equal (state==IDLE), combinationally, independent of req.
REQ-016 A request SHALL be accepted on a rising edge where req=1 and addr_ok=1 (the handshake).
REQ-017 The word index SHALL be addr[ADDR_W+1:2]; addr[1:0] and addr[31:ADDR_W+2] SHALL be ignored, so addresses wrap and alias modulo the memory size.
REQ-018 On an accepted write, the bytes with wstrb[i]=1 SHALL be written at the handshake edge; wstrb=0000 SHALL write nothing but still complete.
REQ-019 On an accepted read, the addressed word SHALL be captured into rdata at the handshake edge, so any later write cannot affect it.
REQ-020 On an accepted write, rdata SHALL retain its previous value.
REQ-021 Transitions when LATENCY=1: IDLE -> RESP on handshake.
REQ-022 Transitions when LATENCY>1: IDLE -> WAIT on handshake, loading the wait counter with LATENCY-1; WAIT decrements the counter each cycle and goes to RESP when it reaches 0 after decrement.
REQ-023 data_sram_data_ok SHALL equal (state==RESP), which lasts exactly one cycle, then RESP -> IDLE unconditionally.
REQ-024 Exactly one transaction SHALL be outstanding at a time; req held high while not in IDLE SHALL be ignored until addr_ok.
REQ-025 Per-request latency SHALL be: handshake at edge T, data_ok high during cycle T+LATENCY, next addr_ok during cycle T+LATENCY+1.
REQ-026 Back-to-back throughput SHALL be one request per LATENCY+1 cycles.
REQ-027 A write and a subsequent read to the same word SHALL return the written data, with byte-merge per wstrb.
REQ-028 data_sram_size SHALL NOT alter behaviour; misaligned or inconsistent size/wstrb combinations SHALL complete normally using wstrb as given.

Reset
REQ-029 When resetn=0 at a rising edge, the block SHALL set state=IDLE, the wait counter to 0 and rdata to 32'h0, so that addr_ok=1 and data_ok=0 after the edge.
REQ-030 A reset asserted during WAIT or RESP SHALL abandon the transaction with no data_ok; a write already committed at its handshake SHALL remain in memory.
REQ-031 Memory array contents SHALL NOT be reset.

Structure
REQ-032 A shared package SHALL hold the FSM state encoding (IDLE/WAIT/RESP), the size codes (SIZE_B/SIZE_H/SIZE_W) and the data width constant 32.
REQ-033 The storage SHALL be a sub-module data_ram_array: a single-port synchronous RAM with 4 byte enables, parameter ADDR_W, and a registered read port.
REQ-034 The FSM, the counter and the handshake logic SHALL live in data_sram_responder.

Verification
REQ-035 With LATENCY=1, write addr 0x10, wdata 0xDEADBEEF, wstrb 1111, then read 0x10 -> data_ok one cycle after each handshake, and the read returns 0xDEADBEEF.
REQ-036 Write 0x11223344 to 0x20, then write 0xAABBCCDD to 0x20 with wstrb 0101, then read 0x20 -> returns 0x11BB33DD.
REQ-037 With LATENCY=4 and req held high for 20 cycles -> addr_ok at cycles 0, 5, 10, 15; data_ok at cycles 4, 9, 14, 19; never both high in one cycle.
REQ-038 With ADDR_W=10, write 0x5A5A5A5A to 0x0000_1004, then read 0x0000_0004 -> returns 0x5A5A5A5A (alias/wrap).
REQ-039 With LATENCY=3, accept a read, assert resetn=0 for one cycle during WAIT -> no data_ok, addr_ok=1 the cycle after reset, rdata=0.
REQ-040 Read from 0x30 (holding 0x0), and in the cycle after its handshake the bench drives a write of 0xFFFFFFFF to 0x30 -> that write is not accepted before RESP, and the read returns 0x0.
